// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two cores,
// with per-core lock (idle timeout) and misaligned-access rejection.
module shared_mem_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int TO_W         = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic        c0_lock,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c0_wdata,
    output logic [31:0] c0_rdata,
    output logic        c0_ready,
    output logic        c0_err,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic        c1_lock,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c1_wdata,
    output logic [31:0] c1_rdata,
    output logic        c1_ready,
    output logic        c1_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state;
    logic            last_grant;
    logic            lock_vld;
    logic            lock_id;
    logic            cur_id;
    logic            cur_lock;
    logic            cur_mis;
    logic [TO_W-1:0] to_cnt;

    logic            elig0;
    logic            elig1;
    logic            winner;
    logic            sel_we;
    logic            sel_lock;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;

    // A core whose ready pulse is still high is excluded, giving the other core the gap cycle.
    assign elig0 = c0_req && !c0_ready && (!lock_vld || !lock_id);
    assign elig1 = c1_req && !c1_ready && (!lock_vld ||  lock_id);

    always_comb begin
        winner    = elig1;
        if (elig0 && elig1)
            winner = ~last_grant;
        sel_we    = winner ? c1_we    : c0_we;
        sel_lock  = winner ? c1_lock  : c0_lock;
        sel_addr  = winner ? c1_addr  : c0_addr;
        sel_wdata = winner ? c1_wdata : c0_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lock_vld   <= 1'b0;
            lock_id    <= 1'b0;
            cur_id     <= 1'b0;
            cur_lock   <= 1'b0;
            cur_mis    <= 1'b0;
            to_cnt     <= '0;
            c0_rdata   <= '0;
            c0_ready   <= 1'b0;
            c0_err     <= 1'b0;
            c1_rdata   <= '0;
            c1_ready   <= 1'b0;
            c1_err     <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            c0_ready <= 1'b0;
            c0_err   <= 1'b0;
            c1_ready <= 1'b0;
            c1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        last_grant <= winner;
                        cur_id     <= winner;
                        cur_lock   <= sel_lock;
                        cur_mis    <= (sel_addr[1:0] != 2'b00);
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_we     <= sel_we && (sel_addr[1:0] == 2'b00);
                        to_cnt     <= '0;
                        if (sel_lock) begin
                            lock_vld <= 1'b1;
                            lock_id  <= winner;
                        end
                        state <= ISSUE;
                    end else if (lock_vld) begin
                        // Owner is idle here (it would otherwise be eligible and granted).
                        if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                            lock_vld <= 1'b0;
                            to_cnt   <= '0;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    if (cur_id) begin
                        c1_ready <= 1'b1;
                        c1_err   <= cur_mis;
                        c1_rdata <= cur_mis ? 32'd0 : mem_rdata;
                    end else begin
                        c0_ready <= 1'b1;
                        c0_err   <= cur_mis;
                        c0_rdata <= cur_mis ? 32'd0 : mem_rdata;
                    end
                    if (!cur_lock && lock_vld && (lock_id == cur_id))
                        lock_vld <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a read-before-write memory model.
module tb_shared_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c0_req, c0_we, c0_lock;
    logic [31:0] c0_addr, c0_wdata, c0_rdata;
    logic        c0_ready, c0_err;
    logic        c1_req, c1_we, c1_lock;
    logic [31:0] c1_addr, c1_wdata, c1_rdata;
    logic        c1_ready, c1_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    int          we_cnt = 0;
    int          rdy0_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    shared_mem_arbiter #(.LOCK_TIMEOUT(4), .TO_W(5)) dut (
        .clock(clock), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .c0_ready(c0_ready), .c0_err(c0_err),
        .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr),
        .c1_wdata(c1_wdata), .c1_rdata(c1_rdata), .c1_ready(c1_ready), .c1_err(c1_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr[11:2]];
        if (mem_we)
            mem[mem_addr[11:2]] <= mem_wdata;
        else if (pl_we)
            mem[pl_idx] <= pl_dat;
        if (mem_we)
            we_cnt <= we_cnt + 1;
        if (c0_ready)
            rdy0_cnt <= rdy0_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input bit core, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(core ? c1_ready : c0_ready) && n < 40);
        if (!(core ? c1_ready : c0_ready))
            chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input bit core, input bit we, input bit lk,
                          input logic [31:0] a, input logic [31:0] d, output int n);
        if (core) begin
            c1_req = 1; c1_we = we; c1_lock = lk; c1_addr = a; c1_wdata = d;
        end else begin
            c0_req = 1; c0_we = we; c0_lock = lk; c0_addr = a; c0_wdata = d;
        end
        wait_rdy(core, n);
        if (core) begin c1_req = 0; c1_lock = 0; end
        else      begin c0_req = 0; c0_lock = 0; end
    endtask

    logic [9:0]  pre_idx [10] = '{10'd4, 10'd8, 10'd9, 10'd16, 10'd17, 10'd18, 10'd19, 10'd20, 10'd64, 10'd65};
    logic [31:0] pre_dat [10] = '{32'h0, 32'h11, 32'h22, 32'hAAAA0000, 32'h55, 32'h66, 32'h99, 32'h0, 32'hA0, 32'hB0};

    initial begin
        int n, w0, r0, order [4];
        logic [31:0] data [4];
        int cnt, first_c, last_c, cyc;

        reset = 1;
        c0_req = 1; c0_we = 0; c0_lock = 0; c0_addr = 32'h100; c0_wdata = 0;
        c1_req = 1; c1_we = 0; c1_lock = 0; c1_addr = 32'h104; c1_wdata = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            pl_we = 1; pl_idx = pre_idx[i]; pl_dat = pre_dat[i];
        end
        @(negedge clock); pl_we = 0;
        @(negedge clock);

        // Reset state with both requests high
        chk("rst_ready", {30'd0, c1_ready, c0_ready}, 32'd0);
        chk("rst_err", {30'd0, c1_err, c0_err}, 32'd0);
        chk("rst_rdata0", c0_rdata, 32'd0);
        chk("rst_rdata1", c1_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // First grant after release goes to core 0, then core 1 in the gap
        reset = 0;
        @(negedge clock);
        chk("first_grant_addr", mem_addr, 32'h100);
        wait_rdy(0, n);
        chk("first_c0_lat", n, 2);
        chk("first_c0_rdata", c0_rdata, 32'hA0);
        c0_req = 0;
        wait_rdy(1, n);
        chk("first_c1_lat", n, 3);
        chk("first_c1_rdata", c1_rdata, 32'hB0);
        c1_req = 0;
        @(negedge clock);

        // Single write then read
        w0 = we_cnt;
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, n);
        chk("wr_lat", n, 3);
        chk("wr_old_rdata", c0_rdata, 32'h0);
        chk("wr_err", {31'd0, c0_err}, 32'd0);
        @(negedge clock);
        chk("wr_we_pulses", we_cnt - w0, 1);
        chk("ready_clears", {31'd0, c0_ready}, 32'd0);
        chk("rdata_holds", c0_rdata, 32'h0);
        access(0, 0, 0, 32'h10, 32'h0, n);
        chk("rd_lat", n, 3);
        chk("rd_rdata", c0_rdata, 32'hDEADBEEF);
        chk("rd_err", {31'd0, c0_err}, 32'd0);
        @(negedge clock);

        // Contention after a fresh reset: alternating grants
        reset = 1;
        @(negedge clock);
        reset = 0;
        w0 = we_cnt;
        c0_req = 1; c0_we = 0; c0_addr = 32'h20;
        c1_req = 1; c1_we = 0; c1_addr = 32'h24;
        cnt = 0; cyc = 0; first_c = 0; last_c = 0;
        while (cnt < 4 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (c0_ready) begin order[cnt] = 0; data[cnt] = c0_rdata; cnt++; end
            else if (c1_ready) begin order[cnt] = 1; data[cnt] = c1_rdata; cnt++; end
            if (cnt == 1 && first_c == 0) first_c = cyc;
            if (cnt == 4) last_c = cyc;
        end
        c0_req = 0; c1_req = 0;
        chk("cont_count", cnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_order%0d", i), order[i], i % 2);
            chk($sformatf("cont_data%0d", i), data[i], (i % 2) ? 32'h22 : 32'h11);
        end
        chk("cont_span", last_c - first_c, 9);
        chk("cont_no_we", we_cnt - w0, 0);
        @(negedge clock);
        @(negedge clock);

        // Lock: c1 read-locked then write-unlock; c0 waits until lock drops
        w0 = we_cnt;
        c1_req = 1; c1_we = 0; c1_lock = 1; c1_addr = 32'h40;
        @(negedge clock);
        c0_req = 1; c0_we = 0; c0_lock = 0; c0_addr = 32'h44;
        r0 = rdy0_cnt;
        wait_rdy(1, n);
        chk("lock_rd_lat", n, 2);
        chk("lock_rd_rdata", c1_rdata, 32'hAAAA0000);
        c1_we = 1; c1_lock = 0; c1_wdata = 32'hCAFEF00D;
        wait_rdy(1, n);
        chk("lock_b2b_lat", n, 4);
        chk("lock_wr_old", c1_rdata, 32'hAAAA0000);
        chk("lock_c0_blocked", rdy0_cnt - r0, 0);
        c1_req = 0; c1_we = 0;
        wait_rdy(0, n);
        chk("lock_c0_lat", n, 3);
        chk("lock_c0_rdata", c0_rdata, 32'h55);
        c0_req = 0;
        @(negedge clock);
        chk("lock_mem40", mem[16], 32'hCAFEF00D);
        chk("lock_we_pulses", we_cnt - w0, 1);

        // Lock timeout: c1 holds lock then goes idle
        c1_req = 1; c1_we = 0; c1_lock = 1; c1_addr = 32'h48;
        @(negedge clock);
        c0_req = 1; c0_we = 0; c0_lock = 0; c0_addr = 32'h4C;
        wait_rdy(1, n);
        chk("to_c1_rdata", c1_rdata, 32'h66);
        c1_req = 0; c1_lock = 0;
        repeat (4) @(negedge clock);
        chk("to_not_yet", mem_addr, 32'h48);
        @(negedge clock);
        chk("to_grant_c0", mem_addr, 32'h4C);
        wait_rdy(0, n);
        chk("to_c0_lat", n, 2);
        chk("to_c0_rdata", c0_rdata, 32'h99);
        c0_req = 0;
        @(negedge clock);
        // Lock is gone: c1 no longer blocks c0 when both ask
        access(0, 0, 0, 32'h20, 32'h0, n);
        chk("to_released_lat", n, 3);

        // Misaligned write rejected
        @(negedge clock);
        w0 = we_cnt;
        access(1, 1, 0, 32'h13, 32'h12345678, n);
        chk("mis_lat", n, 3);
        chk("mis_err", {31'd0, c1_err}, 32'd1);
        chk("mis_rdata", c1_rdata, 32'h0);
        @(negedge clock);
        chk("mis_err_clears", {31'd0, c1_err}, 32'd0);
        chk("mis_no_we", we_cnt - w0, 0);
        access(0, 0, 0, 32'h10, 32'h0, n);
        chk("mis_after_rd", c0_rdata, 32'hDEADBEEF);
        @(negedge clock);

        // Reset during ISSUE: write commits, no ready
        r0 = rdy0_cnt;
        c0_req = 1; c0_we = 1; c0_addr = 32'h50; c0_wdata = 32'h77;
        @(negedge clock);
        reset = 1; c0_req = 0; c0_we = 0;
        @(negedge clock);
        chk("rst_issue_commit", mem[20], 32'h77);
        chk("rst_issue_we", {31'd0, mem_we}, 32'd0);
        reset = 0;
        repeat (4) @(negedge clock);
        chk("rst_issue_no_ready", rdy0_cnt - r0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Two-port arbiter that shares the single-port shared data memory between core 0 and core 1 of the dual-core CPU. It sits between the two cores' load/store units and the memory block. It serialises their accesses with round-robin fairness and supports a per-core lock for multi-access atomic sequences, with a timeout. It also rejects misaligned word accesses before they reach memory.

## Interface
Parameters:
- LOCK_TIMEOUT, 16: IDLE cycles a lock owner may hold the lock without requesting before forced release (≥1).
- TO_W, 5: width of the lock timeout counter; must hold LOCK_TIMEOUT.

Ports (clock is `clock`; reset is synchronous, active-high, named `reset`):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous active-high reset
- c0_req  in  1  core 0 access request, held until c0_ready
- c0_we  in  1  core 0 write (1) / read (0)
- c0_lock  in  1  core 0 keeps ownership after this access
- c0_addr  in  32  core 0 byte address
- c0_wdata  in  32  core 0 write data
- c0_rdata  out  32  core 0 read data, valid with c0_ready
- c0_ready  out  1  one-cycle completion pulse
- c0_err  out  1  misaligned-access flag, valid with c0_ready
- c1_req, c1_we, c1_lock, c1_addr, c1_wdata, c1_rdata, c1_ready, c1_err: same as core 0
- mem_addr  out  32  to memory addr
- mem_we  out  1  to memory write_enable
- mem_wdata  out  32  to memory write_data
- mem_rdata  in  32  from memory read_data; registered, valid one cycle after address

## Operation
- State machine: IDLE → ISSUE → RESP → IDLE. All outputs are registered.
- Reset values: every output is 0. State = IDLE. last_grant = 1 (core 0 wins the first tie). lock_owner = none. Timeout counter = 0.
- Eligibility in IDLE: core x is eligible if cx_req=1, cx_ready=0 this cycle, and lock_owner is none or x.
- Arbitration:
  - One eligible core: that core wins.
  - Both eligible: the core ≠ last_grant wins.
  - On grant: last_grant ← winner; latch we, lock, addr, wdata.
- Issue:
  - mem_addr ← addr, mem_wdata ← wdata.
  - mem_we ← we only if addr[1:0]==0; otherwise mem_we ← 0.
  - Go to ISSUE.
- ISSUE: memory performs the access at the ISSUE-ending edge. mem_we ← 0 at that edge. Go to RESP.
- RESP:
  - cx_rdata ← mem_rdata (0 if misaligned); cx_err ← misaligned; cx_ready ← 1.
  - Go to IDLE.
  - Ready, rdata and err clear the following cycle; rdata holds its value until the next completion for that core.
- Write responses: rdata returns the word's prior content (read-before-write memory).
- Lock:
  - A granted access with lock=1 sets lock_owner = winner.
  - A granted access with lock=0 by the owner clears lock_owner when that access completes in RESP.
  - A misaligned access still obeys these lock rules.
- Timeout counter:
  - Counts while state=IDLE, lock_owner≠none and the owner is not eligible.
  - Resets to 0 on any grant.
  - On reaching LOCK_TIMEOUT, lock_owner ← none and the counter ← 0.
- Address and data pass to memory unmodified; memory uses only bits [11:2].

## Timing
- A request sampled at edge E0 in IDLE sees cx_ready high in the cycle after E2: fixed 3-edge latency, including misaligned and write accesses.
- mem_we is high for exactly one cycle (the ISSUE cycle).
- Bus throughput is one access per 3 cycles.
- A core holding req for back-to-back accesses is re-eligible one cycle after its ready pulse, so peak per-core rate is one per 4 cycles.
- Because of the ready exclusion, the other core is granted in that gap cycle if it is requesting.
- Reset during ISSUE: the write still commits at that edge (memory has no reset). No ready is issued, and all state returns to reset values.
- Reset in any other state abandons the access with no ready.
- Requests that arrive while state≠IDLE wait; no request is dropped.

## Test plan
- Reset: hold reset 2 cycles with both reqs high → all outputs 0. The first grant after release goes to core 0.
- Single write then read: c0 write 0xDEADBEEF to 0x10 → c0_ready 3 edges later with c0_rdata = 0 (old value). c0 read 0x10 → c0_rdata = 0xDEADBEEF, c0_err = 0.
- Contention: c0 and c1 request at the same edge, reading 0x20/0x24 preloaded 0x11/0x22, and keep requesting → grants alternate 0,1,0,1. Each returns its own word; mem_we is never high.
- Lock: c1 reads 0x40 with lock=1, then writes 0x40 with lock=0, while c0_req is held → c0 is granted only after c1's second ready. Final memory[0x40] holds c1's data.
- Lock timeout (LOCK_TIMEOUT=4): c1 locked access, then c1_req=0, while c0 requests → c0 granted exactly 4 IDLE cycles after c1's ready cycle, and lock_owner is cleared.
- Misaligned: c1 write 0x12345678 to 0x13 → c1_ready with c1_err=1, c1_rdata=0, mem_we never high. A subsequent read of 0x10 returns its unchanged contents.
